writeback_unit: RTL and testbench

//  Write-side driver of the integer register file.
//  - Accepts results from the ALU and load/store producers over valid/ready handshakes.
//  - Buffers them in order in a small FIFO.
//  - Drives the register file write port (we/index/data) at one write per cycle.
//  - Exports a pending-write mask so issue logic can stall on RAW hazards until each write lands.

---
 rtl/wb_pkg.sv | 15 +
 rtl/writeback_unit_if.sv | 41 ++++
 rtl/wb_fifo.sv | 73 +++++++
 rtl/writeback_unit.sv | 116 +++++++++++
 tb/tb_writeback_unit.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared widths and the queued-result record for the register file writeback path.
package wb_pkg;
  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NREGS      = 2**REG_ADDR_W;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_ADDR_W-1:0] rd);
    return NREGS'(1) << rd;
  endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// Producer handshakes, register file write port and hazard mask of the writeback unit.
// Optional forwarding lookup signals exist only when BYPASS_EN is defined.
interface writeback_unit_if;
  import wb_pkg::*;

  logic                  mem_valid;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic [XLEN-1:0]       mem_data;
  logic                  mem_ready;
  logic                  alu_valid;
  logic [REG_ADDR_W-1:0] alu_rd;
  logic [XLEN-1:0]       alu_data;
  logic                  alu_ready;
  logic                  rf_we;
  logic [REG_ADDR_W-1:0] rf_waddr;
  logic [XLEN-1:0]       rf_wdata;
  logic [NREGS-1:0]      pending_mask;
`ifdef BYPASS_EN
  logic [REG_ADDR_W-1:0] fwd_idx;
  logic                  fwd_hit;
  logic [XLEN-1:0]       fwd_data;
`endif

  modport slave (
    input  mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
`ifdef BYPASS_EN
    input  fwd_idx,
    output fwd_hit, fwd_data,
`endif
    output mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, pending_mask
  );

  modport master (
    output mem_valid, mem_rd, mem_data, alu_valid, alu_rd, alu_data,
`ifdef BYPASS_EN
    output fwd_idx,
    input  fwd_hit, fwd_data,
`endif
    input  mem_ready, alu_ready, rf_we, rf_waddr, rf_wdata, pending_mask
  );
endinterface

// File: rtl/wb_fifo.sv
// Two-push/one-pop circular buffer of writeback entries with an oldest-first view of contents.
// The data view is only exported when BYPASS_EN is defined.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push0,
  input  wb_entry_t             i_entry0,
  input  logic                  i_push1,
  input  wb_entry_t             i_entry1,
  input  logic                  i_pop,
  output wb_entry_t             o_head,
  output logic [CNT_W-1:0]      o_count,
  output logic [DEPTH-1:0]      o_age_valid,
  output logic [REG_ADDR_W-1:0] o_age_rd [DEPTH]
`ifdef BYPASS_EN
  ,
  output logic [XLEN-1:0]       o_age_data [DEPTH]
`endif
);

  wb_entry_t         r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;
  logic              w_pop;
  logic [1:0]        w_npush;
  logic [PTR_W-1:0]  w_wr_ptr1;

  assign w_pop     = i_pop && (r_count != '0);
  assign w_npush   = {1'b0, i_push0} + {1'b0, i_push1};
  // A lone second push takes the first free slot so entries stay contiguous.
  assign w_wr_ptr1 = i_push0 ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_rd_ptr <= r_rd_ptr + PTR_W'(w_pop);
      r_wr_ptr <= r_wr_ptr + PTR_W'(w_npush);
      r_count  <= r_count + CNT_W'(w_npush) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wr_ptr]  <= i_entry0;
    if (i_push1) r_mem[w_wr_ptr1] <= i_entry1;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_comb begin
    logic [PTR_W-1:0] w_idx;
    w_idx = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx          = r_rd_ptr + PTR_W'(k);
      o_age_valid[k] = CNT_W'(k) < r_count;
      o_age_rd[k]    = r_mem[w_idx].rd;
`ifdef BYPASS_EN
      o_age_data[k]  = r_mem[w_idx].data;
`endif
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Register file write-side driver: accepts ALU/load results, queues them, writes one per cycle.
// BYPASS_EN adds a combinational youngest-match forwarding lookup.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  writeback_unit_if.slave  wb
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]      w_count;
  logic                  w_mem_ready;
  logic                  w_alu_ready;
  logic                  w_push0;
  logic                  w_push1;
  logic                  w_pop;
  wb_entry_t             w_entry0;
  wb_entry_t             w_entry1;
  wb_entry_t             w_head;
  logic [DEPTH-1:0]      w_age_valid;
  logic [REG_ADDR_W-1:0] w_age_rd [DEPTH];
  logic [NREGS-1:0]      w_mask;
  logic                  r_rf_we;
  logic [REG_ADDR_W-1:0] r_rf_waddr;
  logic [XLEN-1:0]       r_rf_wdata;
`ifdef BYPASS_EN
  logic [XLEN-1:0]       w_age_data [DEPTH];
  logic                  w_fwd_hit;
  logic [XLEN-1:0]       w_fwd_data;
`endif

  // Readiness deliberately ignores the pop happening in the same cycle.
  assign w_mem_ready = w_count < CNT_W'(DEPTH);
  assign w_alu_ready = (w_count + CNT_W'(wb.mem_valid & w_mem_ready)) < CNT_W'(DEPTH);

  assign w_push0  = wb.mem_valid && w_mem_ready && (wb.mem_rd != '0);
  assign w_push1  = wb.alu_valid && w_alu_ready && (wb.alu_rd != '0);
  assign w_entry0 = '{rd: wb.mem_rd, data: wb.mem_data};
  assign w_entry1 = '{rd: wb.alu_rd, data: wb.alu_data};
  assign w_pop    = w_count != '0;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push0     (w_push0),
    .i_entry0    (w_entry0),
    .i_push1     (w_push1),
    .i_entry1    (w_entry1),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (w_count),
    .o_age_valid (w_age_valid),
    .o_age_rd    (w_age_rd)
`ifdef BYPASS_EN
    ,
    .o_age_data  (w_age_data)
`endif
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf_we    <= 1'b0;
      r_rf_waddr <= '0;
      r_rf_wdata <= '0;
    end else if (w_pop) begin
      r_rf_we    <= 1'b1;
      r_rf_waddr <= w_head.rd;
      r_rf_wdata <= w_head.data;
    end else begin
      r_rf_we    <= 1'b0;
    end
  end

  always_comb begin
    w_mask = '0;
    if (r_rf_we) w_mask = rd_onehot(r_rf_waddr);
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (w_age_valid[k]) w_mask = w_mask | rd_onehot(w_age_rd[k]);
    end
  end

`ifdef BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins; the output register is oldest.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    if (wb.fwd_idx != '0) begin
      if (r_rf_we && (r_rf_waddr == wb.fwd_idx)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_rf_wdata;
      end
      for (int unsigned k = 0; k < DEPTH; k++) begin
        if (w_age_valid[k] && (w_age_rd[k] == wb.fwd_idx)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = w_age_data[k];
        end
      end
    end
  end

  assign wb.fwd_hit  = w_fwd_hit;
  assign wb.fwd_data = w_fwd_data;
`endif

  assign wb.mem_ready    = w_mem_ready;
  assign wb.alu_ready    = w_alu_ready;
  assign wb.rf_we        = r_rf_we;
  assign wb.rf_waddr     = r_rf_waddr;
  assign wb.rf_wdata     = r_rf_wdata;
  assign wb.pending_mask = w_mask;

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized self-checking bench for writeback_unit against a queue-based reference model.
module tb_writeback_unit;
  import wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  typedef struct {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data;
  } m_ent_t;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  m_ent_t                q[$];
  logic                  m_we;
  logic [REG_ADDR_W-1:0] m_waddr;
  logic [XLEN-1:0]       m_wdata;
  logic [XLEN-1:0]       rf_obs [NREGS];
`ifdef BYPASS_EN
  logic [REG_ADDR_W-1:0] tb_fidx;
`endif

  writeback_unit_if wb ();

  writeback_unit #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NREGS-1:0] exp_mask();
    logic [NREGS-1:0] m;
    m = '0;
    if (m_we) m[m_waddr] = 1'b1;
    foreach (q[i]) m[q[i].rd] = 1'b1;
    return m;
  endfunction

  task automatic model_reset();
    q.delete();
    m_we    = 1'b0;
    m_waddr = '0;
    m_wdata = '0;
  endtask

  // Call just after a negedge; returns on the following negedge.
  task automatic step(input logic mv, input logic [REG_ADDR_W-1:0] mrd, input logic [XLEN-1:0] md,
                      input logic av, input logic [REG_ADDR_W-1:0] ard, input logic [XLEN-1:0] ad);
    logic   exp_mr, exp_ar;
    m_ent_t e;
    wb.mem_valid = mv;  wb.mem_rd = mrd;  wb.mem_data = md;
    wb.alu_valid = av;  wb.alu_rd = ard;  wb.alu_data = ad;
`ifdef BYPASS_EN
    wb.fwd_idx = tb_fidx;
`endif
    #1;
    exp_mr = q.size() < DEPTH;
    exp_ar = (q.size() + ((mv && exp_mr) ? 1 : 0)) < DEPTH;
    chk("mem_ready", 64'(wb.mem_ready), 64'(exp_mr));
    chk("alu_ready", 64'(wb.alu_ready), 64'(exp_ar));
    @(posedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      m_we = 1'b1;  m_waddr = e.rd;  m_wdata = e.data;
    end else begin
      m_we = 1'b0;
    end
    if (mv && exp_mr && mrd != 0) q.push_back('{rd: mrd, data: md});
    if (av && exp_ar && ard != 0) q.push_back('{rd: ard, data: ad});
    #1;
    chk("rf_we",        64'(wb.rf_we),        64'(m_we));
    chk("rf_waddr",     64'(wb.rf_waddr),     64'(m_waddr));
    chk("rf_wdata",     64'(wb.rf_wdata),     64'(m_wdata));
    chk("pending_mask", 64'(wb.pending_mask), 64'(exp_mask()));
`ifdef BYPASS_EN
    begin
      logic            hit;
      logic [XLEN-1:0] dat;
      hit = 1'b0;  dat = '0;
      if (tb_fidx != 0) begin
        if (m_we && m_waddr == tb_fidx) begin hit = 1'b1; dat = m_wdata; end
        foreach (q[i]) if (q[i].rd == tb_fidx) begin hit = 1'b1; dat = q[i].data; end
      end
      chk("fwd_hit",  64'(wb.fwd_hit),  64'(hit));
      chk("fwd_data", 64'(wb.fwd_data), 64'(dat));
    end
`endif
    if (wb.rf_we) rf_obs[wb.rf_waddr] = wb.rf_wdata;
    wb.mem_valid = 1'b0;
    wb.alu_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, '0, '0);
  endtask

  // Call just after a negedge; checks the asynchronous clear before any clock edge.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_rf_we",    64'(wb.rf_we),        64'(0));
    chk("rst_waddr",    64'(wb.rf_waddr),     64'(0));
    chk("rst_wdata",    64'(wb.rf_wdata),     64'(0));
    chk("rst_mask",     64'(wb.pending_mask), 64'(0));
    chk("rst_mem_rdy",  64'(wb.mem_ready),    64'(1));
    chk("rst_alu_rdy",  64'(wb.alu_ready),    64'(1));
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    foreach (rf_obs[i]) rf_obs[i] = '0;
`ifdef BYPASS_EN
    tb_fidx    = '0;
    wb.fwd_idx = '0;
`endif
    // Reset held with both producers offering results.
    rst_n = 1'b0;
    wb.mem_valid = 1'b1;  wb.mem_rd = 5'd9;   wb.mem_data = 32'h1234;
    wb.alu_valid = 1'b1;  wb.alu_rd = 5'd10;  wb.alu_data = 32'h5678;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_hold_we",   64'(wb.rf_we),        64'(0));
    chk("rst_hold_mask", 64'(wb.pending_mask), 64'(0));
    wb.mem_valid = 1'b0;
    wb.alu_valid = 1'b0;
    rst_n = 1'b1;
    idle(2);

    // Single ALU write and its pending bit lifetime.
    step(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF);
    chk("t2_pend_q", 64'(wb.pending_mask[5]), 64'(1));
    idle(1);
    chk("t2_we",   64'(wb.rf_we),    64'(1));
    chk("t2_data", 64'(wb.rf_wdata), 64'(32'hDEADBEEF));
    idle(1);
    chk("t2_pend_clr", 64'(wb.pending_mask[5]), 64'(0));

    // Same-cycle writes to one register: youngest (alu) value lands last.
    step(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    idle(3);
    chk("t3_rf3", 64'(rf_obs[3]), 64'(32'h22));

    // Back-to-back dual pushes drive occupancy up to the alu_ready limit.
    for (int i = 0; i < 5; i++)
      step(1'b1, 5'(i + 1), 32'(100 + i), 1'b1, 5'(i + 11), 32'(200 + i));
    idle(5);

    // x0 results complete their handshake but are never written.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFF_FFFF);
    step(1'b1, 5'd0, 32'h77, 1'b0, '0, '0);
    idle(2);

    // Reset while three entries are queued.
    step(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hA2);
    step(1'b1, 5'd4, 32'hA4, 1'b1, 5'd6, 32'hA6);
    do_reset();
    idle(4);

`ifdef BYPASS_EN
    tb_fidx = 5'd7;
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'hA);
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'hB);
    chk("byp_hit",  64'(wb.fwd_hit),  64'(1));
    chk("byp_data", 64'(wb.fwd_data), 64'(32'hB));
    idle(3);
`endif

    // Randomized traffic with small rd range to provoke collisions and x0 results.
    for (int i = 0; i < 400; i++) begin
`ifdef BYPASS_EN
      tb_fidx = 5'($urandom_range(0, 7));
`endif
      if (i == 200) do_reset();
      step(1'($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom(),
           1'($urandom_range(0, 99) < 65), 5'($urandom_range(0, 7)), $urandom());
    end
    idle(6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
